// File: rtl/ssd_scan_router.sv
// ssd_scan_router: programmable digit route table, per-frame snapshot, multiplexed 7-seg scan.
// Latency: an_n/seg_n registered one cycle behind digit_idx; snapshot refreshed once per frame.
// Backpressure: none, free-running scan. Optional blink feature: define SSD_SCAN_ROUTER_BLINK_EN.
`timescale 1ns/1ps
module ssd_scan_router #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_W    = 4,
  parameter int NUM_SRC    = 16,
  parameter int MODE_W     = 3,
  parameter int LOCK_MODE  = 0,
  parameter int SCAN_DIV   = 50000,
  localparam int DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MODE_W-1:0]          mode,
  input  logic                       auth,
  input  logic [NUM_SRC*DIGIT_W-1:0] src_bus,
  input  logic                       cfg_we,
  input  logic [MODE_W-1:0]          cfg_mode,
  input  logic [DIG_W-1:0]           cfg_digit,
  input  logic [SRC_W-1:0]           cfg_src,
  input  logic                       cfg_blank,
`ifdef SSD_SCAN_ROUTER_BLINK_EN
  input  logic                       cfg_blink,
`endif
  output logic                       cfg_err,
  output logic [NUM_DIGITS-1:0]      an_n,
  output logic [6:0]                 seg_n,
  output logic [DIG_W-1:0]           digit_idx,
  output logic                       frame_done
);

  localparam int                ROWS     = 1 << MODE_W;
  localparam int                PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [MODE_W-1:0] LOCK_ROW = MODE_W'(LOCK_MODE);

  // Route table: one source index and one blank flag per (row, digit).
  logic [SRC_W-1:0]      tbl_src   [ROWS][NUM_DIGITS];
  logic [NUM_DIGITS-1:0] tbl_blank [ROWS];

  // Frame snapshot: values captured at the frame wrap, displayed for the whole next frame.
  logic [DIGIT_W-1:0]    snap_val  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dark;

  logic [DIGIT_W-1:0]    nxt_val   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] nxt_dark;

  logic [PRE_W-1:0]  prescaler;
  logic              tick;
  logic              wrap;
  logic              cfg_ok;
  logic              cur_dark;
  logic [MODE_W-1:0] eff;

`ifdef SSD_SCAN_ROUTER_BLINK_EN
  logic [NUM_DIGITS-1:0] tbl_blink [ROWS];
  logic [NUM_DIGITS-1:0] snap_blink;
  logic                  blink_phase;
`endif

  assign tick   = (prescaler == PRE_LAST);
  assign wrap   = tick && (digit_idx == DIG_LAST);
  assign eff    = auth ? mode : LOCK_ROW;
  assign cfg_ok = cfg_we && (int'(cfg_digit) < NUM_DIGITS);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Table writes land at the clock edge; out-of-range digits are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        tbl_blank[r] <= '1;
`ifdef SSD_SCAN_ROUTER_BLINK_EN
        tbl_blink[r] <= '0;
`endif
        for (int d = 0; d < NUM_DIGITS; d++) tbl_src[r][d] <= '0;
      end
    end else if (cfg_ok) begin
      tbl_src[cfg_mode][cfg_digit]   <= cfg_src;
      tbl_blank[cfg_mode][cfg_digit] <= cfg_blank;
`ifdef SSD_SCAN_ROUTER_BLINK_EN
      tbl_blink[cfg_mode][cfg_digit] <= cfg_blink;
`endif
    end
  end

  // One-cycle error pulse for a write aimed past the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_we && !cfg_ok;
  end

  // Slot prescaler, digit scan counter and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        prescaler <= '0;
        digit_idx <= wrap ? '0 : digit_idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Route each digit through the effective row; a source index past NUM_SRC never matches and stays dark.
  always_comb begin
    for (int d = 0; d < NUM_DIGITS; d++) begin
      nxt_val[d]  = '0;
      nxt_dark[d] = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (tbl_src[eff][d] == SRC_W'(k)) begin
          nxt_val[d]  = src_bus[k*DIGIT_W +: DIGIT_W];
          nxt_dark[d] = tbl_blank[eff][d];
        end
      end
    end
  end

  // Capture the whole frame at the wrap so mode/auth/table changes never tear a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_dark <= '1;
      for (int d = 0; d < NUM_DIGITS; d++) snap_val[d] <= '0;
`ifdef SSD_SCAN_ROUTER_BLINK_EN
      snap_blink  <= '0;
      blink_phase <= 1'b0;
`endif
    end else if (wrap) begin
      snap_dark <= nxt_dark;
      for (int d = 0; d < NUM_DIGITS; d++) snap_val[d] <= nxt_val[d];
`ifdef SSD_SCAN_ROUTER_BLINK_EN
      snap_blink  <= tbl_blink[eff];
      blink_phase <= ~blink_phase;
`endif
    end
  end

`ifdef SSD_SCAN_ROUTER_BLINK_EN
  assign cur_dark = snap_dark[digit_idx] | (snap_blink[digit_idx] & blink_phase);
`else
  assign cur_dark = snap_dark[digit_idx];
`endif

  // Drive pins from the current slot; a dark digit turns every anode off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= '1;
      seg_n <= 7'h7F;
    end else begin
      an_n  <= cur_dark ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
      seg_n <= cur_dark ? 7'h7F : hex7(snap_val[digit_idx][3:0]);
    end
  end

endmodule
